ps2_scancode_parser: RTL and testbench

PS2_SCANCODE_PARSER -- requirements
Module: ps2_scancode_parser

---
 rtl/ps2_pkg.sv | 29 ++
 rtl/ps2_rx.sv | 145 ++++++++++++++
 rtl/ps2_scancode_parser.sv | 96 +++++++++
 tb/tb_ps2_scancode_parser.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants, receiver state type and reply-code helper for the PS/2 scancode parser
package ps2_pkg;

    // Parser prefix bytes
    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    // Keyboard controller reply bytes (never key codes when no prefix is pending)
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;

    // Parameter defaults
    localparam int FILTER_LEN_DEF     = 8;
    localparam int TIMEOUT_CYCLES_DEF = 100000;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_SHIFT = 2'd1,
        RX_CHECK = 2'd2
    } rx_state_t;

    function automatic logic is_reply(input logic [7:0] b);
        return (b == PS2_BAT_OK) || (b == PS2_ACK) ||
               (b == PS2_ECHO)   || (b == PS2_RESEND);
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 frame receiver: synchronizers, clock glitch filter, frame FSM, idle timeout
//
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   ps2_clk         raw PS/2 clock pin
//   ps2_data        raw PS/2 data pin
//   rx_byte         received data byte, valid while byte_valid is high
//   byte_valid      one-cycle strobe, one clk after the stop-bit filtered edge
//   frame_err       one-cycle pulse when a frame is dropped
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = FILTER_LEN_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_flt;
    logic [FW-1:0] flt_cnt;
    logic          fall;

    rx_state_t     state, state_nxt;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic          stop_bit;
    logic [TW-1:0] tcnt;
    logic          timeout;
    logic          frame_ok;
    logic          data_s;

    assign data_s = data_sync[1];

    // Synchronizers preset to the idle-bus level so reset release never looks like an edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // The filtered clock only follows the synchronized clock after FILTER_LEN
    // consecutive disagreeing samples; any agreeing sample restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_flt <= 1'b1;
            flt_cnt <= '0;
            fall    <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_sync[1] == clk_flt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_flt <= clk_sync[1];
                flt_cnt <= '0;
                fall    <= ~clk_sync[1];
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    assign timeout  = (state == RX_SHIFT) && !fall && (tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign frame_ok = stop_bit && (^{shreg, par_bit});

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RX_IDLE;
        else       state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            RX_IDLE:  if (fall && !data_s) state_nxt = RX_SHIFT;
            RX_SHIFT: begin
                if (timeout)                      state_nxt = RX_IDLE;
                else if (fall && bit_cnt == 4'd9) state_nxt = RX_CHECK;
            end
            RX_CHECK: state_nxt = RX_IDLE;
            default:  state_nxt = RX_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (state)
            RX_IDLE:  frame_err = fall && data_s;
            RX_SHIFT: frame_err = timeout;
            RX_CHECK: begin
                byte_valid = frame_ok;
                frame_err  = !frame_ok;
            end
            default: ;
        endcase
    end

    assign rx_byte = shreg;

    // Bit counter indexes the edge after the start bit: 0-7 data, 8 parity, 9 stop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            stop_bit <= 1'b0;
        end else if (state == RX_IDLE) begin
            bit_cnt <= '0;
        end else if (state == RX_SHIFT && fall) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt < 4'd8)       shreg    <= {data_s, shreg[7:1]};
            else if (bit_cnt == 4'd8) par_bit  <= data_s;
            else                      stop_bit <= data_s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt <= '0;
        end else if (state == RX_IDLE || fall) begin
            tcnt <= '0;
        end else if (!timeout) begin
            tcnt <= tcnt + 1'b1;
        end
    end

endmodule

// File: rtl/ps2_scancode_parser.sv
// rtl/ps2_scancode_parser.sv - PS/2 keyboard scancode parser: prefix handling and typematic suppression
//
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   ps2_clk         raw PS/2 clock pin
//   ps2_data        raw PS/2 data pin
//   scancode        last emitted key code, held between pulses
//   push_down       one-cycle make pulse
//   push_up         one-cycle break pulse
//   extended        code carried an E0 prefix, held with scancode
//   frame_err       one-cycle pulse when a frame is dropped
module ps2_scancode_parser
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = FILTER_LEN_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scancode,
    output logic       push_down,
    output logic       push_up,
    output logic       extended,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       brk;
    logic       ext;
    logic       held_valid;
    logic       held_ext;
    logic [7:0] held_code;
    logic       held_match;

    ps2_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_byte    (rx_byte),
        .byte_valid (rx_valid),
        .frame_err  (frame_err)
    );

    // Held register remembers the key currently down, so auto-repeat makes are swallowed
    assign held_match = held_valid && ({held_ext, held_code} == {ext, rx_byte});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scancode   <= 8'h00;
            extended   <= 1'b0;
            push_down  <= 1'b0;
            push_up    <= 1'b0;
            brk        <= 1'b0;
            ext        <= 1'b0;
            held_valid <= 1'b0;
            held_ext   <= 1'b0;
            held_code  <= 8'h00;
        end else begin
            push_down <= 1'b0;
            push_up   <= 1'b0;
            if (frame_err) begin
                // A dropped frame may have been the key code a prefix was waiting for
                brk <= 1'b0;
                ext <= 1'b0;
            end else if (rx_valid) begin
                if (rx_byte == PS2_BREAK) begin
                    brk <= 1'b1;
                end else if (rx_byte == PS2_EXT) begin
                    ext <= 1'b1;
                end else if (brk || ext || !is_reply(rx_byte)) begin
                    scancode <= rx_byte;
                    extended <= ext;
                    brk      <= 1'b0;
                    ext      <= 1'b0;
                    if (brk) begin
                        push_up <= 1'b1;
                        if (held_match) held_valid <= 1'b0;
                    end else begin
                        push_down  <= !held_match;
                        held_valid <= 1'b1;
                        held_ext   <= ext;
                        held_code  <= rx_byte;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_parser.sv
// tb/tb_ps2_scancode_parser.sv - scoreboard bench for the PS/2 scancode parser
module tb_ps2_scancode_parser;

    localparam int TO = 2000;

    localparam logic [2:0] EV_DOWN = 3'b001;
    localparam logic [2:0] EV_UP   = 3'b010;
    localparam logic [2:0] EV_ERR  = 3'b100;

    typedef struct packed {
        logic [2:0] kind;
        logic       ext;
        logic [7:0] code;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] scancode;
    logic       push_down;
    logic       push_up;
    logic       extended;
    logic       frame_err;

    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    ps2_scancode_parser #(
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .scancode  (scancode),
        .push_down (push_down),
        .push_up   (push_up),
        .extended  (extended),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input logic [2:0] kind, input logic [7:0] code, input logic ext);
        ev_t e;
        e.kind = kind;
        e.code = code;
        e.ext  = ext;
        exp_q.push_back(e);
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_cyc(10);
        ps2_clk = 1'b0;
        wait_cyc(20);
        ps2_clk = 1'b1;
        wait_cyc(10);
    endtask

    task automatic send_frame(input logic [7:0] b, input int nbits = 11,
                              input logic bad_par = 1'b0, input logic bad_stop = 1'b0);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(f[i]);
        ps2_data = 1'b1;
    endtask

    // Every pulse from the DUT is matched against the oldest expected event
    always @(negedge clk) begin
        if (!reset) begin
            if (push_down && push_up)
                check_eq("down_up_overlap", {30'd0, push_down, push_up}, 32'd0);
            if (push_down || push_up || frame_err) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_event", {29'd0, frame_err, push_up, push_down}, 32'd0);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check_eq("event_kind", {29'd0, frame_err, push_up, push_down}, {29'd0, e.kind});
                    if (!frame_err) begin
                        check_eq("scancode", {24'd0, scancode}, {24'd0, e.code});
                        check_eq("extended", {31'd0, extended}, {31'd0, e.ext});
                    end
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(5);
        check_eq("rst_scancode",  {24'd0, scancode}, 32'd0);
        check_eq("rst_extended",  {31'd0, extended}, 32'd0);
        check_eq("rst_push_down", {31'd0, push_down}, 32'd0);
        check_eq("rst_push_up",   {31'd0, push_up}, 32'd0);
        check_eq("rst_frame_err", {31'd0, frame_err}, 32'd0);
        reset = 1'b0;
        wait_cyc(20);

        // Make and break
        expect_ev(EV_DOWN, 8'h1C, 1'b0);
        send_frame(8'h1C);
        send_frame(8'hF0);
        expect_ev(EV_UP, 8'h1C, 1'b0);
        send_frame(8'h1C);

        // Extended make and break
        send_frame(8'hE0);
        expect_ev(EV_DOWN, 8'h75, 1'b1);
        send_frame(8'h75);
        send_frame(8'hE0);
        send_frame(8'hF0);
        expect_ev(EV_UP, 8'h75, 1'b1);
        send_frame(8'h75);

        // Typematic repeat suppressed
        expect_ev(EV_DOWN, 8'h12, 1'b0);
        send_frame(8'h12);
        send_frame(8'h12);
        send_frame(8'h12);
        send_frame(8'hF0);
        expect_ev(EV_UP, 8'h12, 1'b0);
        send_frame(8'h12);

        // Controller replies ignored
        send_frame(8'hAA);
        send_frame(8'hFA);

        // Bad parity drops the byte and the pending break prefix
        send_frame(8'hF0);
        expect_ev(EV_ERR, 8'h00, 1'b0);
        send_frame(8'h1C, 11, 1'b1, 1'b0);
        expect_ev(EV_DOWN, 8'h1C, 1'b0);
        send_frame(8'h1C);

        // Bad stop bit, then start bit of 1
        expect_ev(EV_ERR, 8'h00, 1'b0);
        send_frame(8'h33, 11, 1'b0, 1'b1);
        expect_ev(EV_ERR, 8'h00, 1'b0);
        send_bit(1'b1);

        // Partial frame times out
        expect_ev(EV_ERR, 8'h00, 1'b0);
        send_frame(8'h58, 5);
        wait_cyc(TO + 500);
        expect_ev(EV_DOWN, 8'h58, 1'b0);
        send_frame(8'h58);

        // Reset mid-frame with clock glitches
        send_frame(8'h2B, 4);
        reset = 1'b1;
        wait_cyc(3);
        check_eq("midrst_scancode",  {24'd0, scancode}, 32'd0);
        check_eq("midrst_extended",  {31'd0, extended}, 32'd0);
        check_eq("midrst_push_down", {31'd0, push_down}, 32'd0);
        check_eq("midrst_frame_err", {31'd0, frame_err}, 32'd0);
        reset = 1'b0;
        wait_cyc(10);
        for (int g = 0; g < 4; g++) begin
            ps2_clk = 1'b0;
            wait_cyc(2);
            ps2_clk = 1'b1;
            wait_cyc(15);
        end
        check_eq("glitch_scancode", {24'd0, scancode}, 32'd0);
        expect_ev(EV_DOWN, 8'h1B, 1'b0);
        send_frame(8'h1B);

        wait_cyc(200);
        check_eq("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
